// File: rtl/regbank_port_arbiter_pkg.sv
// Shared constants and request payload for the register-bank port arbiter.
package regbank_port_arbiter_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned REG_W            = 4;
  localparam int unsigned CNT_W_DEF        = 4;
  localparam int unsigned STARVE_LIMIT_DEF = 8;
  localparam int unsigned CH_NUM           = 3;

  localparam logic [1:0] CH_CPU0 = 2'd0;
  localparam logic [1:0] CH_CPU1 = 2'd1;
  localparam logic [1:0] CH_DBG  = 2'd2;

  typedef struct packed {
    logic [REG_W-1:0]  idx;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/regarb_starve_ctr.sv
// Counts consecutive stalled debug-channel cycles, saturating at the limit;
// starve_c flags that the debug channel must be force-granted.
module regarb_starve_ctr
  import regbank_port_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic starve_c
);

  logic [CNT_W-1:0] cnt;

  // Any cycle that is not a stall (handshake or no request) restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!stall) begin
      cnt <= '0;
    end else if (cnt != CNT_W'(STARVE_LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starve_c = (cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/regbank_port_arbiter.sv
// Shares the two ports of the dual-port register bank among ch0/ch1 (CPU) and ch2 (debug).
// Define REGARB_FWD_EN to forward same-cycle write data to a read of the same register.
module regbank_port_arbiter #(
  parameter int unsigned DATA_W       = regbank_port_arbiter_pkg::DATA_W,
  parameter int unsigned REG_W        = regbank_port_arbiter_pkg::REG_W,
  parameter int unsigned STARVE_LIMIT = regbank_port_arbiter_pkg::STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = regbank_port_arbiter_pkg::CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ch0_valid,
  output logic              ch0_ready,
  input  logic [REG_W-1:0]  ch0_reg,
  input  logic              ch0_we,
  input  logic [DATA_W-1:0] ch0_wdata,
  output logic              ch0_rsp_valid,
  output logic [DATA_W-1:0] ch0_rsp_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  input  logic [REG_W-1:0]  ch1_reg,
  input  logic              ch1_we,
  input  logic [DATA_W-1:0] ch1_wdata,
  output logic              ch1_rsp_valid,
  output logic [DATA_W-1:0] ch1_rsp_data,
  input  logic              ch2_valid,
  output logic              ch2_ready,
  input  logic [REG_W-1:0]  ch2_reg,
  input  logic              ch2_we,
  input  logic [DATA_W-1:0] ch2_wdata,
  output logic              ch2_rsp_valid,
  output logic [DATA_W-1:0] ch2_rsp_data,
  output logic [REG_W-1:0]  bank_reg0,
  output logic              bank_we0,
  output logic [DATA_W-1:0] bank_din0,
  input  logic [DATA_W-1:0] bank_dout0,
  output logic [REG_W-1:0]  bank_reg1,
  output logic              bank_we1,
  output logic [DATA_W-1:0] bank_din1,
  input  logic [DATA_W-1:0] bank_dout1,
  output logic              starve_active
);

  import regbank_port_arbiter_pkg::req_t;
  import regbank_port_arbiter_pkg::CH_NUM;
  import regbank_port_arbiter_pkg::CH_CPU0;
  import regbank_port_arbiter_pkg::CH_CPU1;
  import regbank_port_arbiter_pkg::CH_DBG;

  req_t              req [CH_NUM];
  logic              starve;
  logic              use0, use1;
  logic [1:0]        src0, src1;
  logic [CH_NUM-1:0] ready;
  logic              rd0, rd1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [CH_NUM-1:0] rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q [CH_NUM];

  always_comb begin
    req[CH_CPU0] = '{idx: ch0_reg, we: ch0_we, wdata: ch0_wdata};
    req[CH_CPU1] = '{idx: ch1_reg, we: ch1_we, wdata: ch1_wdata};
    req[CH_DBG]  = '{idx: ch2_reg, we: ch2_we, wdata: ch2_wdata};
  end

  regarb_starve_ctr #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .stall    (ch2_valid && !ready[CH_DBG]),
    .starve_c (starve)
  );

  // Port assignment, then same-register write conflict resolution by priority.
  always_comb begin
    use0 = 1'b0;
    use1 = 1'b0;
    src0 = CH_CPU0;
    src1 = CH_CPU1;
    if (!reset) begin
      if (ch0_valid) begin
        use0 = 1'b1;
        src0 = CH_CPU0;
      end
      if (starve) begin
        if (!ch0_valid) begin
          if (ch2_valid) begin
            use0 = 1'b1;
            src0 = CH_DBG;
          end
          if (ch1_valid) begin
            use1 = 1'b1;
            src1 = CH_CPU1;
          end
        end else if (ch2_valid) begin
          use1 = 1'b1;
          src1 = CH_DBG;
        end
      end else begin
        if (ch1_valid) begin
          use1 = 1'b1;
          src1 = CH_CPU1;
        end
        if (ch2_valid && !ch0_valid) begin
          use0 = 1'b1;
          src0 = CH_DBG;
        end else if (ch2_valid && !ch1_valid) begin
          use1 = 1'b1;
          src1 = CH_DBG;
        end
      end
      // Port 0 holds the debug channel only when ch1 is on port 1, so it is the lower one.
      if (use0 && use1 && req[src0].we && req[src1].we &&
          req[src0].idx == req[src1].idx && req[src0].idx != '0) begin
        if (src0 == CH_DBG) use0 = 1'b0;
        else                use1 = 1'b0;
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      ready[k] = (use0 && src0 == 2'(k)) || (use1 && src1 == 2'(k));
    end
  end

  // Bank port drive; register 0 writes are swallowed here.
  always_comb begin
    bank_reg0 = '0;
    bank_we0  = 1'b0;
    bank_din0 = '0;
    bank_reg1 = '0;
    bank_we1  = 1'b0;
    bank_din1 = '0;
    if (use0) begin
      bank_reg0 = req[src0].idx;
      bank_we0  = req[src0].we && (req[src0].idx != '0);
      if (req[src0].we) bank_din0 = req[src0].wdata;
    end
    if (use1) begin
      bank_reg1 = req[src1].idx;
      bank_we1  = req[src1].we && (req[src1].idx != '0);
      if (req[src1].we) bank_din1 = req[src1].wdata;
    end
  end

  always_comb begin
    rd0    = use0 && !req[src0].we;
    rd1    = use1 && !req[src1].we;
    rdata0 = (bank_reg0 == '0) ? '0 : bank_dout0;
    rdata1 = (bank_reg1 == '0) ? '0 : bank_dout1;
`ifdef REGARB_FWD_EN
    if (bank_we1 && bank_reg1 == bank_reg0) rdata0 = bank_din1;
    if (bank_we0 && bank_reg0 == bank_reg1) rdata1 = bank_din0;
`endif
  end

  // Read responses appear one cycle after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      for (int k = 0; k < CH_NUM; k++) rsp_data_q[k] <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        rsp_valid_q[k] <= (rd0 && src0 == 2'(k)) || (rd1 && src1 == 2'(k));
        if (rd0 && src0 == 2'(k))      rsp_data_q[k] <= rdata0;
        else if (rd1 && src1 == 2'(k)) rsp_data_q[k] <= rdata1;
      end
    end
  end

  assign ch0_ready     = ready[CH_CPU0];
  assign ch1_ready     = ready[CH_CPU1];
  assign ch2_ready     = ready[CH_DBG];
  assign ch0_rsp_valid = rsp_valid_q[CH_CPU0];
  assign ch1_rsp_valid = rsp_valid_q[CH_CPU1];
  assign ch2_rsp_valid = rsp_valid_q[CH_DBG];
  assign ch0_rsp_data  = rsp_data_q[CH_CPU0];
  assign ch1_rsp_data  = rsp_data_q[CH_CPU1];
  assign ch2_rsp_data  = rsp_data_q[CH_DBG];
  assign starve_active = starve && !reset;

endmodule

// File: tb/tb_regbank_port_arbiter.sv
// Directed bench for regbank_port_arbiter with a behavioural 16x32 bank and a
// response scoreboard fed from a reference register image.
module tb_regbank_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        tv   [3];
  logic [3:0]  treg [3];
  logic        twe  [3];
  logic [31:0] twd  [3];
  logic [2:0]  rdy, rv;
  logic [31:0] rdat [3];
  logic [3:0]  br0, br1;
  logic        bwe0, bwe1;
  logic [31:0] bd0, bd1, bq0, bq1;
  logic        starve;

  logic [31:0] mem  [16];
  logic [31:0] refm [16];

  typedef struct {
    int          ch;
    logic [31:0] d;
  } exp_t;
  exp_t sb [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regbank_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ch0_valid     (tv[0]),
    .ch0_ready     (rdy[0]),
    .ch0_reg       (treg[0]),
    .ch0_we        (twe[0]),
    .ch0_wdata     (twd[0]),
    .ch0_rsp_valid (rv[0]),
    .ch0_rsp_data  (rdat[0]),
    .ch1_valid     (tv[1]),
    .ch1_ready     (rdy[1]),
    .ch1_reg       (treg[1]),
    .ch1_we        (twe[1]),
    .ch1_wdata     (twd[1]),
    .ch1_rsp_valid (rv[1]),
    .ch1_rsp_data  (rdat[1]),
    .ch2_valid     (tv[2]),
    .ch2_ready     (rdy[2]),
    .ch2_reg       (treg[2]),
    .ch2_we        (twe[2]),
    .ch2_wdata     (twd[2]),
    .ch2_rsp_valid (rv[2]),
    .ch2_rsp_data  (rdat[2]),
    .bank_reg0     (br0),
    .bank_we0      (bwe0),
    .bank_din0     (bd0),
    .bank_dout0    (bq0),
    .bank_reg1     (br1),
    .bank_we1      (bwe1),
    .bank_din1     (bd1),
    .bank_dout1    (bq1),
    .starve_active (starve)
  );

  function automatic logic [31:0] init_val(input int i);
    return (i == 3) ? 32'hDEAD_BEEF : (32'h5A00_0000 | 32'(i));
  endfunction

  // Behavioural register bank: combinational read, clocked write.
  assign bq0 = mem[br0];
  assign bq1 = mem[br1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else begin
      if (bwe0) mem[br0] <= bd0;
      if (bwe1) mem[br1] <= bd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [3:0] r,
                       input logic w, input logic [31:0] d);
    tv[k]   = v;
    treg[k] = r;
    twe[k]  = w;
    twd[k]  = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 4'd0, 1'b0, 32'd0);
  endtask

  // One clock: check grants, queue expected read data, advance, check responses.
  task automatic cyc(input logic [2:0] er, input logic es, input string tag);
    logic [31:0] d;
    logic [2:0]  ev;
    logic [31:0] ed [3];
    exp_t        e;
    #2;
    chk({tag, ".ready"}, 32'(rdy), 32'(er));
    chk({tag, ".starve"}, 32'(starve), 32'(es));
    for (int k = 0; k < 3; k++) begin
      if (er[k] && !twe[k]) begin
        d = (treg[k] == 4'd0) ? 32'd0 : refm[treg[k]];
`ifdef REGARB_FWD_EN
        for (int j = 0; j < 3; j++)
          if (j != k && er[j] && twe[j] && treg[j] == treg[k] && treg[k] != 4'd0) d = twd[j];
`endif
        sb.push_back('{ch: k, d: d});
      end
    end
    for (int k = 0; k < 3; k++)
      if (er[k] && twe[k] && treg[k] != 4'd0) refm[treg[k]] = twd[k];
    @(posedge clk);
    #1;
    ev = '0;
    for (int k = 0; k < 3; k++) ed[k] = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ev[e.ch] = 1'b1;
      ed[e.ch] = e.d;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.rsp_valid%0d", tag, k), 32'(rv[k]), 32'(ev[k]));
      if (ev[k]) chk($sformatf("%s.rsp_data%0d", tag, k), rdat[k], ed[k]);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    for (int i = 0; i < 16; i++) refm[i] = init_val(i);
    @(posedge clk);
    #1;

    // Requests held during reset must not be granted or reach the bank.
    for (int k = 0; k < 3; k++) drive(k, 1'b1, 4'd3, 1'b1, 32'h1234);
    #1;
    chk("rst.bank_we", 32'({bwe0, bwe1}), 32'd0);
    chk("rst.bank_reg0", 32'(br0), 32'd0);
    chk("rst.bank_din1", bd1, 32'd0);
    cyc(3'b000, 1'b0, "rst0");
    cyc(3'b000, 1'b0, "rst1");

    reset = 1'b0;
    idle_all();
    #1;
    chk("idle.bank_we", 32'({bwe0, bwe1}), 32'd0);
    cyc(3'b000, 1'b0, "idle");

    // Dual read of the same register.
    drive(0, 1'b1, 4'd3, 1'b0, 32'd0);
    drive(1, 1'b1, 4'd3, 1'b0, 32'd0);
    cyc(3'b011, 1'b0, "rr3");

    // Same-register write conflict defers ch1 by one cycle.
    drive(0, 1'b1, 4'd5, 1'b1, 32'h11);
    drive(1, 1'b1, 4'd5, 1'b1, 32'h22);
    #1;
    chk("wconf.bank_we1", 32'(bwe1), 32'd0);
    cyc(3'b001, 1'b0, "wconf");
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0);
    cyc(3'b010, 1'b0, "wconf2");
    drive(1, 1'b0, 4'd0, 1'b0, 32'd0);
    drive(0, 1'b1, 4'd5, 1'b0, 32'd0);
    cyc(3'b001, 1'b0, "rd5");

    // Debug starvation: 8 stalled cycles, then a forced grant on port 1.
    drive(0, 1'b1, 4'd1, 1'b0, 32'd0);
    drive(1, 1'b1, 4'd2, 1'b0, 32'd0);
    drive(2, 1'b1, 4'd7, 1'b0, 32'd0);
    for (int i = 0; i < 8; i++) cyc(3'b011, 1'b0, $sformatf("stall%0d", i));
    #1;
    chk("force.bank_reg1", 32'(br1), 32'd7);
    cyc(3'b101, 1'b1, "force");
    drive(2, 1'b0, 4'd0, 1'b0, 32'd0);
    cyc(3'b011, 1'b0, "clr");
    idle_all();

    // Register 0: write swallowed, read returns zero.
    drive(2, 1'b1, 4'd0, 1'b1, 32'hFF);
    #1;
    chk("r0w.bank_we0", 32'(bwe0), 32'd0);
    cyc(3'b100, 1'b0, "r0w");
    drive(2, 1'b1, 4'd0, 1'b0, 32'd0);
    cyc(3'b100, 1'b0, "r0r");
    idle_all();

    // Same-cycle write and read of r9 on opposite ports.
    drive(0, 1'b1, 4'd9, 1'b1, 32'hABCD);
    drive(1, 1'b1, 4'd9, 1'b0, 32'd0);
    cyc(3'b011, 1'b0, "raw9");
    idle_all();
    drive(1, 1'b1, 4'd9, 1'b0, 32'd0);
    cyc(3'b010, 1'b0, "rd9");
    idle_all();

    // ch1/ch2 write conflict with ch0 idle defers the debug channel.
    drive(1, 1'b1, 4'd4, 1'b1, 32'h44);
    drive(2, 1'b1, 4'd4, 1'b1, 32'h55);
    cyc(3'b010, 1'b0, "wconf12");
    drive(1, 1'b0, 4'd0, 1'b0, 32'd0);
    cyc(3'b100, 1'b0, "wconf12b");
    idle_all();
    drive(0, 1'b1, 4'd4, 1'b0, 32'd0);
    cyc(3'b001, 1'b0, "rd4");
    idle_all();
    cyc(3'b000, 1'b0, "tail");

    chk("mem5", mem[5], 32'h22);
    chk("mem0", mem[0], init_val(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
